// File: rtl/conv_pass_sched.sv
// Layer scheduler for the 4-input-channel 3x3 conv core: runs one pass per (output channel, input group),
// streaming image/weight addresses and generating masked output writes with psum prefetch one cycle ahead.
module conv_pass_sched #(
  parameter int IMG_W    = 226,
  parameter int IMG_H    = 226,
  parameter int IN_CH    = 8,
  parameter int OUT_CH   = 4,
  parameter int PIPE_LAT = 457
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        core_rst,
  output logic        img_rd_en,
  output logic [15:0] img_addr,
  output logic [7:0]  ch_grp,
  output logic [7:0]  oc_idx,
  output logic        w_en,
  output logic [15:0] w_addr,
  output logic        psum_rd_en,
  output logic [15:0] psum_addr,
  output logic        psum_zero,
  output logic        out_we,
  output logic [15:0] out_addr,
  output logic        final_pass
);

  localparam int NPIX      = IMG_W * IMG_H;
  localparam int DRAIN_LEN = (PIPE_LAT > 2 * IMG_W) ? PIPE_LAT - 2 * IMG_W : 0;
  localparam int NGRP      = IN_CH / 4;
  localparam int OUT_COLS  = IMG_W - 2;
  localparam int LAST_CNT  = NPIX + DRAIN_LEN - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_STREAM, S_DRAIN, S_NEXT, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pix_cnt_q, pix_cnt_d;
  logic [7:0]  ch_grp_q, ch_grp_d;
  logic [7:0]  oc_idx_q, oc_idx_d;
  logic [15:0] pass_base_q, pass_base_d;
  logic        erun_q, erun_d;
  logic [15:0] erow_q, erow_d;
  logic [15:0] ecol_q, ecol_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic        out_we_q, out_we_d;
  logic [15:0] out_addr_q, out_addr_d;
  logic        counting;
  logic        last_pass;
  logic        e_we;

  assign counting  = (state_q == S_STREAM) || (state_q == S_DRAIN);
  assign last_pass = (ch_grp_q == 8'(NGRP - 1)) && (oc_idx_q == 8'(OUT_CH - 1));

  always_comb begin
    state_d     = state_q;
    ch_grp_d    = ch_grp_q;
    oc_idx_d    = oc_idx_q;
    pass_base_d = pass_base_q;
    pix_cnt_d   = counting ? pix_cnt_q + 16'd1 : 16'd0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_CFG;
          ch_grp_d    = '0;
          oc_idx_d    = '0;
          pass_base_d = '0;
        end
      end
      S_CFG: state_d = S_STREAM;
      S_STREAM: begin
        if (pix_cnt_q == 16'(NPIX - 1)) state_d = (DRAIN_LEN > 0) ? S_DRAIN : S_NEXT;
      end
      S_DRAIN: begin
        if (pix_cnt_q == 16'(LAST_CNT)) state_d = S_NEXT;
      end
      S_NEXT: begin
        // Indices hold on the final pass so the layer's last coordinates stay visible.
        if (last_pass) begin
          state_d = S_DONE;
        end else begin
          state_d     = S_CFG;
          pass_base_d = pass_base_q + 16'd9;
          if (ch_grp_q == 8'(NGRP - 1)) begin
            ch_grp_d = '0;
            oc_idx_d = oc_idx_q + 8'd1;
          end else begin
            ch_grp_d = ch_grp_q + 8'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The e* window walker runs one cycle ahead of out_we so psum reads can be issued early.
  assign e_we = erun_q && (ecol_q < 16'(OUT_COLS));

  always_comb begin
    erun_d = erun_q;
    erow_d = erow_q;
    ecol_d = ecol_q;
    wcnt_d = wcnt_q;
    if (counting && (pix_cnt_q == 16'(PIPE_LAT - 2))) begin
      erun_d = 1'b1;
      erow_d = '0;
      ecol_d = '0;
      wcnt_d = '0;
    end else if (erun_q) begin
      if (e_we) wcnt_d = wcnt_q + 16'd1;
      if (ecol_q == 16'(IMG_W - 1)) begin
        ecol_d = '0;
        if (erow_q == 16'(IMG_H - 3)) erun_d = 1'b0;
        else erow_d = erow_q + 16'd1;
      end else begin
        ecol_d = ecol_q + 16'd1;
      end
    end
    out_we_d   = e_we;
    out_addr_d = e_we ? wcnt_q : out_addr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pix_cnt_q   <= '0;
      ch_grp_q    <= '0;
      oc_idx_q    <= '0;
      pass_base_q <= '0;
      erun_q      <= 1'b0;
      erow_q      <= '0;
      ecol_q      <= '0;
      wcnt_q      <= '0;
      out_we_q    <= 1'b0;
      out_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      ch_grp_q    <= ch_grp_d;
      oc_idx_q    <= oc_idx_d;
      pass_base_q <= pass_base_d;
      erun_q      <= erun_d;
      erow_q      <= erow_d;
      ecol_q      <= ecol_d;
      wcnt_q      <= wcnt_d;
      out_we_q    <= out_we_d;
      out_addr_q  <= out_addr_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign core_rst   = (state_q == S_CFG);
  assign img_rd_en  = (state_q == S_STREAM);
  assign img_addr   = img_rd_en ? pix_cnt_q : 16'd0;
  assign w_en       = img_rd_en && (pix_cnt_q < 16'd9);
  assign w_addr     = pass_base_q + (w_en ? pix_cnt_q : 16'd0);
  assign ch_grp     = ch_grp_q;
  assign oc_idx     = oc_idx_q;
  assign psum_zero  = (ch_grp_q == 8'd0);
  assign final_pass = busy && (ch_grp_q == 8'(NGRP - 1));
  assign psum_rd_en = e_we && !psum_zero;
  assign psum_addr  = wcnt_q;
  assign out_we     = out_we_q;
  assign out_addr   = out_addr_q;

endmodule

// File: tb/tb_conv_pass_sched.sv
// Self-checking bench for conv_pass_sched: a per-cycle arithmetic model of the layer schedule
// (pass index, offset within pass, window position) is compared against every DUT output.
module tb_conv_pass_sched;
  localparam int W     = 6;
  localparam int H     = 6;
  localparam int IC    = 8;
  localparam int OC    = 2;
  localparam int LAT   = 16;
  localparam int NPIX  = W * H;
  localparam int DRN   = (LAT > 2 * W) ? LAT - 2 * W : 0;
  localparam int PLEN  = NPIX + DRN + 2;
  localparam int NGRP  = IC / 4;
  localparam int NPASS = OC * NGRP;
  localparam int TOTAL = NPASS * PLEN + 1;
  localparam int NWR   = (W - 2) * (H - 2);

  logic        clk = 1'b0;
  logic        reset, start;
  logic        busy, done, core_rst, img_rd_en, w_en, psum_rd_en, psum_zero, out_we, final_pass;
  logic [15:0] img_addr, w_addr, psum_addr, out_addr;
  logic [7:0]  ch_grp, oc_idx;

  int n_tests = 0;
  int n_fail  = 0;

  conv_pass_sched #(.IMG_W(W), .IMG_H(H), .IN_CH(IC), .OUT_CH(OC), .PIPE_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .core_rst(core_rst),
    .img_rd_en(img_rd_en), .img_addr(img_addr), .ch_grp(ch_grp), .oc_idx(oc_idx),
    .w_en(w_en), .w_addr(w_addr), .psum_rd_en(psum_rd_en), .psum_addr(psum_addr),
    .psum_zero(psum_zero), .out_we(out_we), .out_addr(out_addr), .final_pass(final_pass)
  );

  always #5 clk = ~clk;

  task automatic test_reset(input int cycles);
    reset = 1'b1;
    start = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
    n_tests++;
    if ({busy, done, core_rst, img_rd_en, w_en, out_we, psum_rd_en, final_pass} !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl got %b want 00000000",
               {busy, done, core_rst, img_rd_en, w_en, out_we, psum_rd_en, final_pass});
    end
    n_tests++;
    if (psum_zero !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_psum_zero got %b want 1", psum_zero);
    end
    n_tests++;
    if ({img_addr, w_addr, psum_addr, out_addr} !== 64'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_addr got %h want 0", {img_addr, w_addr, psum_addr, out_addr});
    end
    n_tests++;
    if ({ch_grp, oc_idx} !== 16'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_idx got %h want 0", {ch_grp, oc_idx});
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_idle got busy=%b want 0", busy);
    end
  endtask

  // noise: 0 = none, 1 = random start pulses while busy, 2 = start held during pass 1 STREAM.
  task automatic test_layer(input int abort_at, input int noise);
    int wr_cnt[NPASS];
    int done_seen, psum_seen, last_addr, idle;
    bit have_last;
    foreach (wr_cnt[i]) wr_cnt[i] = 0;
    done_seen = 0;
    psum_seen = 0;
    last_addr = 0;
    have_last = 1'b0;
    idle = $urandom_range(0, 5);
    for (int i = 0; i < idle; i++) begin
      n_tests++;
      if ({busy, done} !== 2'b00) begin
        n_fail++;
        $display("[TB] FAIL pre_start_idle got %b want 00", {busy, done});
      end
      @(posedge clk);
      #1;
    end
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int t = 0; t < TOTAL; t++) begin
      int  pass, k, grp, oc, pix, p, p2, e_oaddr, e_paddr;
      bit  in_pass, e_str, e_wen, e_we, e_prd;
      logic [6:0] want_ctrl;
      pass    = t / PLEN;
      k       = t % PLEN;
      in_pass = (pass < NPASS);
      grp     = pass % NGRP;
      oc      = pass / NGRP;
      pix     = k - 1;
      e_str   = in_pass && (k >= 1) && (k <= NPIX);
      e_wen   = e_str && (pix < 9);
      p       = k - 1 - LAT;
      p2      = p + 1;
      e_we    = in_pass && (p >= 0) && (p < (H - 2) * W) && ((p % W) < W - 2);
      e_prd   = in_pass && (grp != 0) && (p2 >= 0) && (p2 < (H - 2) * W) && ((p2 % W) < W - 2);
      e_oaddr = (p / W) * (W - 2) + (p % W);
      e_paddr = (p2 / W) * (W - 2) + (p2 % W);
      want_ctrl = {1'b1, !in_pass, in_pass && (k == 0), e_str, e_wen, e_we, e_prd};

      n_tests++;
      if ({busy, done, core_rst, img_rd_en, w_en, out_we, psum_rd_en} !== want_ctrl) begin
        n_fail++;
        $display("[TB] FAIL ctrl t=%0d got %b want %b", t,
                 {busy, done, core_rst, img_rd_en, w_en, out_we, psum_rd_en}, want_ctrl);
      end
      if (in_pass) begin
        n_tests++;
        if ({ch_grp, oc_idx, psum_zero, final_pass} !==
            {8'(grp), 8'(oc), grp == 0, grp == NGRP - 1}) begin
          n_fail++;
          $display("[TB] FAIL idx t=%0d got grp=%0d oc=%0d pz=%b fp=%b want grp=%0d oc=%0d", t,
                   ch_grp, oc_idx, psum_zero, final_pass, grp, oc);
        end
      end
      if (e_str) begin
        n_tests++;
        if (img_addr !== 16'(pix)) begin
          n_fail++;
          $display("[TB] FAIL img_addr t=%0d got %0d want %0d", t, img_addr, pix);
        end
      end
      if (e_wen) begin
        n_tests++;
        if (w_addr !== 16'(pass * 9 + pix)) begin
          n_fail++;
          $display("[TB] FAIL w_addr t=%0d got %0d want %0d", t, w_addr, pass * 9 + pix);
        end
      end
      if (e_we || have_last) begin
        n_tests++;
        if (out_addr !== 16'(e_we ? e_oaddr : last_addr)) begin
          n_fail++;
          $display("[TB] FAIL out_addr t=%0d got %0d want %0d", t, out_addr,
                   e_we ? e_oaddr : last_addr);
        end
      end
      if (e_prd) begin
        n_tests++;
        if (psum_addr !== 16'(e_paddr)) begin
          n_fail++;
          $display("[TB] FAIL psum_addr t=%0d got %0d want %0d", t, psum_addr, e_paddr);
        end
      end
      if (e_we) begin
        last_addr = e_oaddr;
        have_last = 1'b1;
      end
      if (in_pass && out_we === 1'b1) wr_cnt[pass]++;
      if (done === 1'b1) done_seen++;
      if (psum_rd_en === 1'b1) psum_seen++;
      if (t == abort_at) return;

      if (noise == 1) start = ($urandom_range(0, 3) == 0);
      else if (noise == 2) start = (t >= PLEN + 2) && (t < PLEN + 12);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    for (int i = 0; i < NPASS; i++) begin
      n_tests++;
      if (wr_cnt[i] !== NWR) begin
        n_fail++;
        $display("[TB] FAIL writes_pass%0d got %0d want %0d", i, wr_cnt[i], NWR);
      end
    end
    n_tests++;
    if (done_seen !== 1) begin
      n_fail++;
      $display("[TB] FAIL done_count got %0d want 1", done_seen);
    end
    n_tests++;
    if (psum_seen !== NWR * (NPASS - OC)) begin
      n_fail++;
      $display("[TB] FAIL psum_count got %0d want %0d", psum_seen, NWR * (NPASS - OC));
    end
    n_tests++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL post_layer_idle got %b want 00", {busy, done});
    end
  endtask

  task automatic test_random_layers;
    for (int i = 0; i < 2; i++) test_layer(-1, 1);
  endtask

  task automatic test_start_while_busy;
    test_layer(-1, 2);
  endtask

  task automatic test_reset_mid_drain;
    int abort_at;
    abort_at = $urandom_range(0, NPASS - 1) * PLEN + $urandom_range(NPIX + 1, NPIX + DRN);
    test_layer(abort_at, 0);
    test_reset(1);
    test_layer(-1, 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    test_reset(2);
    test_layer(-1, 0);
    test_random_layers();
    test_start_while_busy();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
